// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball sequencer: vsync synchroniser, per-frame tick, serve/play/pause FSM with wall bounce.
// Optional left-wall miss handling is enabled by defining BALL_LEFT_MISS_EN.
module ball_motion_ctrl #(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned BALL_SIZE    = 4,
  parameter int unsigned BALL_X0      = 128,
  parameter int unsigned BALL_Y0      = 128,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] speed,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] state,
  output logic       frame_tick,
  output logic       bounce,
  output logic [7:0] miss_count
);

  localparam int unsigned PW = 10;
  localparam int unsigned EW = PW + 1;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 16;
  localparam logic [EW-1:0] X_LIM = EW'(H_RES - BALL_SIZE);
  localparam logic [EW-1:0] Y_LIM = EW'(V_RES - BALL_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    MISS  = 2'd3
  } state_t;

  state_t        state_q;
  logic          vs_meta, vs_sync, vs_dly;
  logic          dir_x, dir_y;
  logic [SW-1:0] step;
  logic [CW-1:0] frame_cnt;
  logic [PW-1:0] nx, ny;
  logic          ndx, ndy, hit_x, hit_y;
  logic          advance;

  assign state   = state_q;
  assign advance = frame_tick & ~pause;

  // vsync crosses in through two flops; a third gives the rising-edge reference.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_meta    <= 1'b0;
      vs_sync    <= 1'b0;
      vs_dly     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_meta    <= vsync;
      vs_sync    <= vs_meta;
      vs_dly     <= vs_sync;
      frame_tick <= vs_sync & ~vs_dly;
    end
  end

  // Candidate next position/direction per axis, with clamp-and-reflect at the walls.
  always_comb begin
    nx    = ball_x;
    ndx   = dir_x;
    hit_x = 1'b0;
    ny    = ball_y;
    ndy   = dir_y;
    hit_y = 1'b0;
    if (dir_x) begin
      if ((EW'(ball_x) + EW'(step)) >= X_LIM) begin
        nx    = PW'(X_LIM);
        ndx   = 1'b0;
        hit_x = 1'b1;
      end else begin
        nx = ball_x + PW'(step);
      end
    end else begin
      if (ball_x <= PW'(step)) begin
        nx    = '0;
        ndx   = 1'b1;
        hit_x = 1'b1;
      end else begin
        nx = ball_x - PW'(step);
      end
    end
    if (dir_y) begin
      if ((EW'(ball_y) + EW'(step)) >= Y_LIM) begin
        ny    = PW'(Y_LIM);
        ndy   = 1'b0;
        hit_y = 1'b1;
      end else begin
        ny = ball_y + PW'(step);
      end
    end else begin
      if (ball_y <= PW'(step)) begin
        ny    = '0;
        ndy   = 1'b1;
        hit_y = 1'b1;
      end else begin
        ny = ball_y - PW'(step);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ball_x    <= PW'(BALL_X0);
      ball_y    <= PW'(BALL_Y0);
      dir_x     <= 1'b0;
      dir_y     <= 1'b1;
      step      <= SW'(1);
      frame_cnt <= '0;
      bounce    <= 1'b0;
`ifdef BALL_LEFT_MISS_EN
      miss_count <= '0;
`endif
    end else begin
      bounce <= 1'b0;
      case (state_q)
        IDLE: begin
          ball_x <= PW'(BALL_X0);
          ball_y <= PW'(BALL_Y0);
          if (start) begin
            state_q   <= SERVE;
            step      <= SW'(speed) + SW'(1);
            frame_cnt <= '0;
          end
        end
        SERVE: begin
          if (advance) begin
            if (frame_cnt == CW'(SERVE_FRAMES - 1)) begin
              state_q   <= PLAY;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        PLAY: begin
          if (advance) begin
            ball_y <= ny;
            dir_y  <= ndy;
`ifdef BALL_LEFT_MISS_EN
            // Left wall is a goal: park at 0 without reflecting and count the miss.
            if (hit_x && !dir_x) begin
              ball_x    <= '0;
              state_q   <= MISS;
              frame_cnt <= '0;
              bounce    <= hit_y;
              if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
            end else begin
              ball_x <= nx;
              dir_x  <= ndx;
              bounce <= hit_x | hit_y;
            end
`else
            ball_x <= nx;
            dir_x  <= ndx;
            bounce <= hit_x | hit_y;
`endif
          end
        end
        MISS: begin
          if (advance) begin
            if (frame_cnt == CW'(MISS_FRAMES - 1)) begin
              state_q   <= SERVE;
              frame_cnt <= '0;
              ball_x    <= PW'(BALL_X0);
              ball_y    <= PW'(BALL_Y0);
              dir_x     <= 1'b0;
              step      <= SW'(speed) + SW'(1);
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

`ifndef BALL_LEFT_MISS_EN
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl: randomized frames against a signed-velocity reference model.
`timescale 1ns/1ps
module tb_ball_motion_ctrl;
  localparam int X0   = 128;
  localparam int Y0   = 128;
  localparam int SF   = 60;
  localparam int MF   = 30;
  localparam int XLIM = 640 - 4;
  localparam int YLIM = 480 - 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] ball_x, ball_y;
  logic [1:0] state;
  logic       frame_tick, bounce;
  logic [7:0] miss_count;

  int checks = 0;
  int errors = 0;
  int tick_seen = 0;

  int m_state, m_x, m_y, m_sx, m_sy, m_step, m_cnt, m_miss;
  bit m_tick, m_bounce, vh_a, vh_b, vh_c;

  ball_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .pause      (pause),
    .speed      (speed),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .state      (state),
    .frame_tick (frame_tick),
    .bounce     (bounce),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One frame move of a single axis: position plus signed velocity, clamped to [0, lim].
  function automatic void axis(input int p, input int v, input int lim,
                               output int np, output int nv, output bit hit);
    int t;
    t = p + v;
    if (t >= lim) begin
      np = lim; nv = -v; hit = 1'b1;
    end else if (t <= 0) begin
      np = 0; nv = -v; hit = 1'b1;
    end else begin
      np = t; nv = v; hit = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = X0; m_y = Y0; m_sx = -1; m_sy = 1; m_step = 1;
    m_cnt = 0; m_miss = 0; m_tick = 0; m_bounce = 0;
    vh_a = 0; vh_b = 0; vh_c = 0;
  endtask

  task automatic model_edge();
    bit adv, nb, hx, hy;
    int nx, ny, vx, vy;
    adv = m_tick && !pause;
    nb  = 1'b0;
    case (m_state)
      0: begin
        m_x = X0; m_y = Y0;
        if (start) begin m_state = 1; m_step = int'(speed) + 1; m_cnt = 0; end
      end
      1: if (adv) begin
        m_cnt++;
        if (m_cnt == SF) begin m_state = 2; m_cnt = 0; end
      end
      2: if (adv) begin
        axis(m_x, m_sx * m_step, XLIM, nx, vx, hx);
        axis(m_y, m_sy * m_step, YLIM, ny, vy, hy);
        m_y  = ny;
        m_sy = (vy > 0) ? 1 : -1;
`ifdef BALL_LEFT_MISS_EN
        if (m_sx < 0 && hx) begin
          m_x = 0; m_state = 3; m_cnt = 0; nb = hy;
          if (m_miss < 255) m_miss++;
        end else
`endif
        begin
          m_x  = nx;
          m_sx = (vx > 0) ? 1 : -1;
          nb   = hx || hy;
        end
      end
      default: if (adv) begin
        m_cnt++;
        if (m_cnt == MF) begin
          m_state = 1; m_cnt = 0; m_x = X0; m_y = Y0; m_sx = -1;
          m_step = int'(speed) + 1;
        end
      end
    endcase
    m_bounce = nb;
    m_tick   = vh_b && !vh_c;
    vh_c = vh_b; vh_b = vh_a; vh_a = vsync;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (ball_x !== 10'(m_x) || ball_y !== 10'(m_y) || state !== 2'(m_state) ||
          frame_tick !== m_tick || bounce !== m_bounce || miss_count !== 8'(m_miss)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t: dut x=%0d y=%0d st=%0d tick=%0b bnc=%0b miss=%0d, model x=%0d y=%0d st=%0d tick=%0b bnc=%0b miss=%0d",
                 $time, ball_x, ball_y, state, frame_tick, bounce, miss_count,
                 m_x, m_y, m_state, m_tick, m_bounce, m_miss);
      end
      if (reset && frame_tick === 1'b1) tick_seen++;
    end
  end

  task automatic frame();
    int lo;
    lo = int'($urandom_range(4, 9));
    @(negedge clk) vsync = 1'b1;
    @(negedge clk);
    @(negedge clk) vsync = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_x", int'(ball_x), X0);
    chk("rst_y", int'(ball_y), Y0);
    chk("rst_miss", int'(miss_count), 0);
    chk("rst_bounce", int'(bounce), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int np, nv;
    bit hit;
    // Pin the reference axis rule with hand-worked wall cases.
    axis(634, 4, XLIM, np, nv, hit);
    chk("pin_right_x", np, 636); chk("pin_right_v", nv, -4);
    axis(636, -4, XLIM, np, nv, hit);
    chk("pin_after_right", np, 632);
    axis(2, -2, XLIM, np, nv, hit);
    chk("pin_left_x", np, 0); chk("pin_left_hit", int'(hit), 1);
    axis(474, 2, YLIM, np, nv, hit);
    chk("pin_bottom_y", np, 476); chk("pin_bottom_v", nv, -2);

    repeat (3) @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_pos", int'(ball_x) * 1000 + int'(ball_y), 128128);
    reset = 1'b1;
    tick_seen = 0;

    repeat (10) frame();
    repeat (3) @(negedge clk);
    chk("idle_ticks", tick_seen, 10);
    chk("idle_state", int'(state), 0);
    chk("idle_pos", int'(ball_x) * 1000 + int'(ball_y), 128128);

    speed = 2'd1;
    pulse_start();
    chk("serve_entry", int'(state), 1);
    repeat (5) frame();
    pause = 1'b1;
    repeat (5) frame();
    pause = 1'b0;
    repeat (54) frame();
    chk("serve_hold", int'(state), 1);
    frame();
    chk("play_entry", int'(state), 2);
    chk("play_entry_pos", int'(ball_x) * 1000 + int'(ball_y), 128128);
    frame();
    chk("play_tick1", int'(ball_x) * 1000 + int'(ball_y), 126130);
    frame();
    chk("play_tick2", int'(ball_x) * 1000 + int'(ball_y), 124132);
    pause = 1'b1;
    repeat (5) frame();
    pause = 1'b0;
    chk("play_paused", int'(ball_x) * 1000 + int'(ball_y), 124132);
    frame();
    chk("play_resume", int'(ball_x) * 1000 + int'(ball_y), 122134);
    repeat (61) frame();
    chk("left_x", int'(ball_x), 0);
    chk("left_y", int'(ball_y), 256);
`ifdef BALL_LEFT_MISS_EN
    chk("miss_state", int'(state), 3);
    chk("miss_count", int'(miss_count), 1);
    repeat (29) frame();
    chk("miss_hold", int'(state), 3);
    frame();
    chk("reserve_state", int'(state), 1);
    chk("reserve_pos", int'(ball_x) * 1000 + int'(ball_y), 128128);
`else
    chk("left_bounce_state", int'(state), 2);
    frame();
    chk("left_reflect", int'(ball_x) * 1000 + int'(ball_y), 2258);
`endif

    for (int i = 0; i < 250; i++) begin
      pause = ($urandom_range(0, 3) == 0);
      speed = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 7) == 0);
      frame();
    end
    pause = 1'b0;
    start = 1'b0;

`ifdef BALL_LEFT_MISS_EN
    for (int i = 0; i < 600 && m_state != 3; i++) frame();
    chk("reach_miss", int'(state), 3);
`else
    for (int i = 0; i < 600 && m_state != 2; i++) frame();
    chk("reach_play", int'(state), 2);
`endif
    frame();
    async_reset();

    speed = 2'd3;
    pulse_start();
    repeat (SF) frame();
    chk("fast_play", int'(state), 2);
    frame();
    chk("fast_tick1", int'(ball_x) * 1000 + int'(ball_y), 124132);
    for (int i = 0; i < 80; i++) begin
      pause = ($urandom_range(0, 4) == 0);
      speed = 2'($urandom_range(0, 3));
      frame();
    end
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-rate sequencer for the bouncing-ball display path. Synchronises the `vsync` output of `vga_sync` into the `clk` domain, generates one update tick per frame, and steps ball position/velocity through a serve/play/pause state machine with wall bounce. Its `ball_x`/`ball_y` outputs feed the pixel-compare graphics logic directly, so no logic is clocked from `vsync`.

## Interface
- `H_RES`, 640, active width in pixels
- `V_RES`, 480, active height in lines
- `BALL_SIZE`, 4, ball edge length in pixels
- `BALL_X0`, 128, serve X position
- `BALL_Y0`, 128, serve Y position
- `SERVE_FRAMES`, 60, frames held in SERVE before launch (≥1)
- `MISS_FRAMES`, 30, frames held in MISS (≥1)
- `clk` in 1: system clock, the same as `vga_sync`
- `reset` in 1: asynchronous, active-low reset
- `vsync` in 1: raw `vsync` from `vga_sync`; asynchronous to this block's logic
- `start` in 1: level; launches a serve from IDLE
- `pause` in 1: level; freezes motion and counters while high
- `speed` in 2: step magnitude is `speed+1` pixels per frame, latched on entry to SERVE
- `ball_x` out 10: ball left edge
- `ball_y` out 10: ball top edge
- `state` out 2: IDLE=0, SERVE=1, PLAY=2, MISS=3
- `frame_tick` out 1: one-cycle pulse per `vsync` rising edge
- `bounce` out 1: one-cycle pulse on any wall reflection
- `miss_count` out 8: saturating miss counter

## Operation
- **`vsync` synchroniser:** two flops, then an edge detect against a third flop. `frame_tick` = synced & ~delayed.
- **Arithmetic:** positions are 10-bit unsigned. `step` is a 3-bit register. Direction is held as `dir_x` and `dir_y`, where 1 = +.
- **Reset values:**
  - `ball_x`=`BALL_X0`, `ball_y`=`BALL_Y0`
  - `dir_x`=0, `dir_y`=1, `step`=1
  - `state`=IDLE
  - `frame_tick`, `bounce`, `miss_count` = 0
  - frame counter = 0
- **IDLE:** ball held at (`BALL_X0`, `BALL_Y0`). When `start`=1 → SERVE; latch `step`; clear the frame counter.
- **SERVE:** counts `frame_tick`s while `pause`=0. When the counter reaches `SERVE_FRAMES` → PLAY.
- **PLAY:** on `frame_tick` with `pause`=0, each axis updates independently.
  - Moving +X: if `ball_x`+`step` ≥ `H_RES`−`BALL_SIZE`, then `ball_x` ← `H_RES`−`BALL_SIZE`, `dir_x` ← 0, pulse `bounce`. Otherwise `ball_x` += `step`.
  - Moving −X: if `ball_x` ≤ `step`, then `ball_x` ← 0, `dir_x` ← 1, pulse `bounce`. Otherwise `ball_x` −= `step`.
  - Y axis: same rules with `V_RES`.
  - Corner hit: both axes reflect on the same tick; `bounce` is a single pulse.
- **MISS:** entered only when `BALL_LEFT_MISS_EN` is defined (see Configuration).
  - Counts `MISS_FRAMES` ticks, then → SERVE.
  - On the SERVE transition: reload (`BALL_X0`, `BALL_Y0`), set `dir_x`=0, keep `dir_y`, relatch `step`.
- **`start`:** ignored outside IDLE.
- **`pause`:** suppresses the tick effect in every state. A tick that arrives while paused is dropped, not deferred.

## Timing
- `vsync` rising edge to `frame_tick` high: 3 `clk` edges, ±1 edge for synchroniser metastability.
- `frame_tick` high in cycle N:
  - position, direction, state and `bounce` are registered at the end of cycle N
  - new values are visible in cycle N+1
  - `bounce` is high in N+1 only
- IDLE→SERVE: `start` sampled at edge E; `state`=SERVE after E.
- `reset` is asserted asynchronously at any point, including mid-PLAY or mid-MISS. All outputs go to their reset values immediately. Deassertion needs no tick to resume in IDLE.
- `miss_count` saturates at 255.

## Configuration
- `BALL_LEFT_MISS_EN` defined:
  - In PLAY, a −X move with `ball_x` ≤ `step` sets `ball_x` ← 0, does not reflect, does not pulse `bounce`, and goes → MISS.
  - `miss_count` increments on MISS entry.
- `BALL_LEFT_MISS_EN` undefined:
  - The left wall reflects like the others.
  - MISS is unreachable.
  - `miss_count` is tied to 0.

## Test plan
- Reset low, then high, `start`=0, 10 `vsync` pulses → `state`=0, ball at (128,128), 10 `frame_tick` pulses, each 3 edges after `vsync`↑.
- `start`=1 one cycle, `speed`=1, `SERVE_FRAMES`=60 → PLAY after the 60th tick. First PLAY tick gives (126,130); the next gives (124,132).
- `speed`=3 in PLAY, ball driven to x=634 moving +X → next tick x=636 (`H_RES`−`BALL_SIZE`), `dir_x`=0, `bounce` one cycle. Following tick x=632.
- Ball at (2,474) moving −X/+Y, step 2 → corner: (0,476), both directions flip, one `bounce` pulse.
- `pause`=1 across 5 ticks in PLAY and in SERVE → position and counters unchanged, then resume from the same values.
- With `BALL_LEFT_MISS_EN` defined: ball reaches x≤`step` moving −X → `state`=3, `miss_count`=1. After 30 ticks → SERVE at (128,128). Assert `reset` mid-MISS → IDLE, `miss_count`=0.
